mem_refresh_ctl: RTL and testbench

- DRAM refresh sequencer that sits directly upstream of the memory top level.
- Times the refresh interval and keeps a backlog of owed refreshes.
- Requests the memory arbiter via REFRQ_n, waits for RGNT_n, then drives REF_n for a fixed number of clocks and steps a refresh row counter.
- Its REFRQ_n/REF_n outputs connect directly to the same-named memory inputs; RGNT_n comes back from the address-decode arbiter.

---
 rtl/mem_pkg.sv | 15 +
 rtl/mem_refresh_timer.sv | 34 +++
 rtl/mem_refresh_ctl.sv | 118 +++++++++++
 tb/tb_mem_refresh_ctl.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared types and defaults for the DRAM refresh sequencer.
// Holds the refresh FSM state encoding and default timing constants.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    REF,
    REL
  } ref_state_e;

  localparam int unsigned DEF_INTERVAL   = 1560;
  localparam int unsigned DEF_REF_CYCLES = 8;

endpackage

// File: rtl/mem_refresh_timer.sv
// Refresh interval down-counter producing a one-cycle tick.
// Ports: clk_i, rst_i (async, high), en_i gate -> tick_o pulse.
module mem_refresh_timer
  import mem_pkg::*;
#(
  parameter int unsigned INTERVAL = DEF_INTERVAL
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int unsigned CW = $clog2(INTERVAL);
  localparam logic [CW-1:0] RELOAD = CW'(INTERVAL - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Disabled: parked at the reload value so a
  // re-enable always waits a full interval.
  always_comb begin
    cnt_d = cnt_q;
    if (!en_i || cnt_q == '0) cnt_d = RELOAD;
    else                      cnt_d = cnt_q - 1'b1;
  end

  assign tick_o = en_i && (cnt_q == '0);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= RELOAD;
    else       cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_refresh_ctl.sv
// DRAM refresh sequencer: backlog, arbiter handshake, REF strobe, row count.
// In: sysclk, sys_rst, REF_EN, RGNT_n, OVR_CLR. Out: REFRQ_n, REF_n, REF_ROW, REF_PENDING, REF_OVERRUN.
module mem_refresh_ctl
  import mem_pkg::*;
#(
  parameter int unsigned INTERVAL    = DEF_INTERVAL,
  parameter int unsigned REF_CYCLES  = DEF_REF_CYCLES,
  parameter int unsigned MAX_PENDING = 7,
  parameter int unsigned ROW_BITS    = 10,
  parameter int unsigned PEND_BITS   = 3
) (
  input  logic                 sysclk,
  input  logic                 sys_rst,
  input  logic                 REF_EN,
  input  logic                 RGNT_n,
  input  logic                 OVR_CLR,
  output logic                 REFRQ_n,
  output logic                 REF_n,
  output logic [ROW_BITS-1:0]  REF_ROW,
  output logic [PEND_BITS-1:0] REF_PENDING,
  output logic                 REF_OVERRUN
);

  localparam int unsigned CNT_W = $clog2(REF_CYCLES + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(REF_CYCLES);
  localparam logic [PEND_BITS-1:0] PMAX = PEND_BITS'(MAX_PENDING);

  ref_state_e           state_q;
  logic [CNT_W-1:0]     rcnt_q;
  logic [PEND_BITS-1:0] pend_q, pend_d;
  logic [ROW_BITS-1:0]  row_q;
  logic                 ovr_q, ovr_d;
  logic                 refrq_q, ref_q;
  logic                 tick, done;

  mem_refresh_timer #(
    .INTERVAL(INTERVAL)
  ) u_timer (
    .clk_i  (sysclk),
    .rst_i  (sys_rst),
    .en_i   (REF_EN),
    .tick_o (tick)
  );

  // REF is entered with the counter at zero; REF_n goes low on the
  // next edge, so the count reaching LAST marks the last low cycle.
  assign done = (state_q == REF) && (rcnt_q == LAST);

  // A tick and a completion together cancel out. Only a tick
  // with nowhere to go flags an overrun; set beats clear.
  always_comb begin
    pend_d = pend_q;
    ovr_d  = ovr_q;
    if (OVR_CLR) ovr_d = 1'b0;
    if (tick && !done) begin
      if (pend_q == PMAX) ovr_d  = 1'b1;
      else                pend_d = pend_q + 1'b1;
    end else if (done && !tick) begin
      pend_d = pend_q - 1'b1;
    end
  end

  always_ff @(posedge sysclk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q <= IDLE;
      rcnt_q  <= '0;
      pend_q  <= '0;
      ovr_q   <= 1'b0;
      row_q   <= '0;
      refrq_q <= 1'b1;
      ref_q   <= 1'b1;
    end else begin
      pend_q <= pend_d;
      ovr_q  <= ovr_d;
      unique case (state_q)
        IDLE: begin
          if (pend_q != '0 && REF_EN) begin
            state_q <= REQ;
            refrq_q <= 1'b0;
          end
        end
        REQ: begin
          if (!REF_EN) begin
            state_q <= IDLE;
            refrq_q <= 1'b1;
          end else if (!RGNT_n) begin
            state_q <= REF;
            rcnt_q  <= '0;
          end
        end
        REF: begin
          // Grant is not looked at here, so the strobe
          // always runs to its full length.
          if (done) begin
            state_q <= REL;
            ref_q   <= 1'b1;
            refrq_q <= 1'b1;
            row_q   <= row_q + 1'b1;
          end else begin
            ref_q  <= 1'b0;
            rcnt_q <= rcnt_q + 1'b1;
          end
        end
        REL: begin
          if (RGNT_n) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign REFRQ_n     = refrq_q;
  assign REF_n       = ref_q;
  assign REF_ROW     = row_q;
  assign REF_PENDING = pend_q;
  assign REF_OVERRUN = ovr_q;

endmodule

// File: tb/tb_mem_refresh_ctl.sv
// Self-checking bench for mem_refresh_ctl.
// Scoreboarded strobe rows plus a cycle-by-cycle backlog model.
module tb_mem_refresh_ctl;

  localparam int INTERVAL = 16;
  localparam int REF_CYC  = 8;
  localparam int MAXP     = 7;
  localparam int ROWS     = 1024;
  localparam int NWRAP    = 1024;

  logic       clk;
  logic       rst;
  logic       en;
  logic       gnt_n;
  logic       clr;
  logic       refrq_n;
  logic       ref_n;
  logic [9:0] row;
  logic [2:0] pend;
  logic       ovr;

  mem_refresh_ctl #(
    .INTERVAL    (INTERVAL),
    .REF_CYCLES  (REF_CYC),
    .MAX_PENDING (MAXP),
    .ROW_BITS    (10),
    .PEND_BITS   (3)
  ) dut (
    .sysclk      (clk),
    .sys_rst     (rst),
    .REF_EN      (en),
    .RGNT_n      (gnt_n),
    .OVR_CLR     (clr),
    .REFRQ_n     (refrq_n),
    .REF_n       (ref_n),
    .REF_ROW     (row),
    .REF_PENDING (pend),
    .REF_OVERRUN (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;
  int sb_q[$];
  int exp_row;
  int gnt_edge;
  int n_grant;
  int n_strobe;
  int a_st;
  int a_wait;
  bit a_saw;
  bit a_gl;
  bit arb_on;

  // Reference model: edge count since reset, enabled-run length,
  // and the backlog from tick / completion events.
  int   cyc;
  int   run;
  int   m_pend;
  logic m_ovr;
  logic m_tick;
  logic m_done;

  assign m_tick = en && (run == INTERVAL - 1);
  assign m_done = (cyc + 1 == gnt_edge + REF_CYC + 1);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      cyc    <= 0;
      run    <= 0;
      m_pend <= 0;
      m_ovr  <= 1'b0;
    end else begin
      cyc <= cyc + 1;
      run <= !en ? 0 : (m_tick ? 0 : run + 1);
      if (m_tick && !m_done)
        m_pend <= (m_pend < MAXP) ? m_pend + 1 : m_pend;
      else if (m_done && !m_tick)
        m_pend <= m_pend - 1;
      if (m_tick && !m_done && m_pend == MAXP) m_ovr <= 1'b1;
      else if (clr)                            m_ovr <= 1'b0;
    end
  end

  task automatic chk(input string name, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cyc %0d)",
               name, act, want, cyc);
    end
  endtask

  task automatic monitor();
    logic prev;
    int   len;
    int   row0;
    bit   in_s;
    prev = 1'b1;
    len  = 0;
    row0 = 0;
    in_s = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev = 1'b1;
        len  = 0;
        in_s = 1'b0;
      end else begin
        chk("pending", int'(pend), m_pend);
        chk("overrun", int'(ovr), int'(m_ovr));
        if (prev && !ref_n) begin
          in_s = 1'b1;
          len  = 1;
          row0 = int'(row);
          if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL strobe: got row %0d expected no strobe", row0);
          end else begin
            chk("strobe_row", row0, sb_q.pop_front());
          end
        end else if (!ref_n) begin
          len++;
          chk("row_stable", int'(row), row0);
        end else if (in_s) begin
          chk("strobe_len", len, REF_CYC);
          in_s = 1'b0;
          n_strobe++;
        end
        prev = ref_n;
      end
    end
  endtask

  task automatic rst_on();
    @(negedge clk);
    rst      = 1'b1;
    en       = 1'b0;
    gnt_n    = 1'b1;
    clr      = 1'b0;
    sb_q.delete();
    exp_row  = 0;
    gnt_edge = -1000;
    n_grant  = 0;
    n_strobe = 0;
    a_st     = 0;
    a_wait   = 0;
    arb_on   = 1'b0;
    @(negedge clk);
  endtask

  task automatic rst_off();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_cyc(input int k);
    while (cyc < k) @(negedge clk);
  endtask

  task automatic grant_now();
    gnt_n    = 1'b0;
    gnt_edge = cyc + 1;
    sb_q.push_back(exp_row);
    exp_row  = (exp_row + 1) % ROWS;
    n_grant++;
  endtask

  // Arbiter model: random grant delay, random grant glitches
  // while the strobe is low, random release delay in REL.
  task automatic arb_step();
    case (a_st)
      0: begin
        if (arb_on && n_grant < NWRAP && !refrq_n && ref_n) begin
          if (a_wait > 0) a_wait--;
          else begin
            grant_now();
            a_st  = 1;
            a_saw = 1'b0;
            a_gl  = 1'b0;
          end
        end
      end
      1: begin
        if (!ref_n) begin
          a_saw = 1'b1;
          if (a_gl) begin
            gnt_n = 1'b0;
            a_gl  = 1'b0;
          end else if ($urandom_range(0, 3) == 0) begin
            gnt_n = 1'b1;
            a_gl  = 1'b1;
          end
        end else if (a_saw) begin
          gnt_n  = 1'b0;
          a_gl   = 1'b0;
          a_st   = 2;
          a_wait = int'($urandom_range(0, 1));
        end
      end
      default: begin
        if (a_wait > 0) a_wait--;
        else begin
          gnt_n  = 1'b1;
          a_st   = 0;
          a_wait = int'($urandom_range(0, 1));
        end
      end
    endcase
  endtask

  initial begin
    int k;
    errors = 0;
    checks = 0;
    rst    = 1'b1;
    en     = 1'b0;
    gnt_n  = 1'b1;
    clr    = 1'b0;
    fork
      monitor();
    join_none

    // First refresh with grant tied low.
    rst_on();
    chk("rst_refrq", int'(refrq_n), 1);
    chk("rst_ref", int'(ref_n), 1);
    chk("rst_row", int'(row), 0);
    chk("rst_pend", int'(pend), 0);
    chk("rst_ovr", int'(ovr), 0);
    en       = 1'b1;
    gnt_n    = 1'b0;
    gnt_edge = 18;
    sb_q.push_back(0);
    rst_off();
    wait_cyc(16);
    chk("a_refrq16", int'(refrq_n), 1);
    chk("a_pend16", int'(pend), 1);
    wait_cyc(17);
    chk("a_refrq17", int'(refrq_n), 0);
    wait_cyc(18);
    chk("a_ref18", int'(ref_n), 1);
    wait_cyc(19);
    chk("a_ref19", int'(ref_n), 0);
    chk("a_row19", int'(row), 0);
    wait_cyc(26);
    chk("a_ref26", int'(ref_n), 0);
    wait_cyc(27);
    chk("a_ref27", int'(ref_n), 1);
    chk("a_row27", int'(row), 1);
    chk("a_refrq27", int'(refrq_n), 1);

    // Asynchronous reset in the middle of a strobe.
    rst_on();
    en       = 1'b1;
    gnt_n    = 1'b0;
    gnt_edge = 18;
    sb_q.push_back(0);
    rst_off();
    wait_cyc(21);
    chk("b_ref21", int'(ref_n), 0);
    #2 rst = 1'b1;
    #1;
    chk("b_async_ref", int'(ref_n), 1);
    chk("b_async_refrq", int'(refrq_n), 1);
    chk("b_async_pend", int'(pend), 0);
    chk("b_async_row", int'(row), 0);

    // Tick on the last strobe cycle, then REF_EN drops.
    rst_on();
    en = 1'b1;
    rst_off();
    wait_cyc(17);
    chk("c_refrq17", int'(refrq_n), 0);
    wait_cyc(22);
    grant_now();
    wait_cyc(32);
    chk("c_ref32", int'(ref_n), 1);
    chk("c_pend32", int'(pend), 1);
    gnt_n = 1'b1;
    wait_cyc(34);
    chk("c_rereq34", int'(refrq_n), 0);
    en = 1'b0;
    wait_cyc(35);
    chk("c_withdraw", int'(refrq_n), 1);
    chk("c_pend35", int'(pend), 1);
    en = 1'b1;
    wait_cyc(36);
    chk("c_req36", int'(refrq_n), 0);
    grant_now();
    wait_cyc(39);
    en = 1'b0;
    wait_cyc(45);
    chk("c_ref45", int'(ref_n), 0);
    wait_cyc(46);
    chk("c_ref46", int'(ref_n), 1);
    chk("c_pend46", int'(pend), 0);
    gnt_n = 1'b1;
    wait_cyc(50);
    chk("c_idle50", int'(refrq_n), 1);

    // Saturate the backlog, drain it, clear overrun, wrap the row.
    rst_on();
    en = 1'b1;
    rst_off();
    wait_cyc(112);
    chk("d_pend112", int'(pend), 7);
    chk("d_ovr112", int'(ovr), 0);
    wait_cyc(127);
    chk("d_ovr127", int'(ovr), 0);
    wait_cyc(128);
    chk("d_ovr128", int'(ovr), 1);
    chk("d_pend128", int'(pend), 7);
    arb_on = 1'b1;
    k = 0;
    while (m_pend != 0 && k < 3000) begin
      arb_step();
      @(negedge clk);
      k++;
    end
    chk("d_drained", int'(pend), 0);
    chk("d_ovr_sticky", int'(ovr), 1);
    clr = 1'b1;
    arb_step();
    @(negedge clk);
    clr = 1'b0;
    chk("d_ovr_clr", int'(ovr), 0);
    k = 0;
    while (n_strobe < NWRAP && k < 25000) begin
      arb_step();
      @(negedge clk);
      k++;
    end
    chk("d_strobes", n_strobe, NWRAP);
    k = 0;
    while (a_st != 0 && k < 50) begin
      arb_step();
      @(negedge clk);
      k++;
    end
    chk("d_arb_idle", a_st, 0);
    arb_on = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("d_row_wrap", int'(row), 0);
    chk("d_ref_idle", int'(ref_n), 1);
    chk("sb_empty", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
